// File: rtl/stack_bus_pkg.sv
// Shared definitions for the stack CPU word bus and the memory-side responder.
package stack_bus_pkg;
    localparam int WORD_W = 16;
    localparam logic [WORD_W-1:0] IO_ADDR_DEFAULT = 16'hFFFF;
    // Byte the CPU decodes as a no-op; pads an odd-length boot image.
    localparam logic [7:0] NOP_BYTE = 8'h00;

    typedef enum logic [1:0] {
        ST_LOAD       = 2'd0,
        ST_LOAD_FLUSH = 2'd1,
        ST_RUN        = 2'd2
    } ld_state_e;
endpackage

// File: rtl/stack_ram.sv
// Single-port synchronous word RAM with a registered, read-before-write read port.
module stack_ram #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // The read samples the array before the write lands, so a same-address
    // read/write returns the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end
endmodule

// File: rtl/stack_mem_responder.sv
// Memory-side responder: boot loader fills RAM from a byte stream, then the CPU
// gets the RAM plus one memory-mapped I/O word.
module stack_mem_responder
    import stack_bus_pkg::*;
#(
    parameter int                ADDR_W    = 12,
    parameter logic [WORD_W-1:0] IO_ADDR   = IO_ADDR_DEFAULT,
    parameter bit                BOOT_LOAD = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] address,
    input  logic [WORD_W-1:0] wdata,
    input  logic              wr,
    output logic [WORD_W-1:0] rdata,
    input  logic [WORD_W-1:0] io_in,
    output logic [WORD_W-1:0] io_out,
    output logic              io_stb,
    input  logic              ld_valid,
    input  logic [7:0]        ld_byte,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              cpu_run,
    output logic              ld_err
);
    localparam logic [ADDR_W-1:0] PTR_MAX = '1;

    ld_state_e         state_reg;
    logic [ADDR_W-1:0] ptr_reg;
    logic              phase_lo_reg;
    logic [7:0]        hi_reg;
    logic              cpu_run_reg;
    logic              ld_ready_reg;
    logic              ld_err_reg;

    logic              rd_valid_reg;
    logic              rd_io_reg;
    logic [WORD_W-1:0] io_q_reg;
    logic [WORD_W-1:0] io_out_reg;
    logic              io_stb_reg;

    logic              is_io;
    logic              accept;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [WORD_W-1:0] ram_wdata;
    logic [WORD_W-1:0] ram_q;

    assign is_io  = (address == IO_ADDR);
    assign accept = ld_valid && ld_ready_reg && (state_reg == ST_LOAD);

    // RAM port belongs to the loader until RUN, then to the CPU.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = ptr_reg;
        ram_wdata = {hi_reg, ld_byte};
        case (state_reg)
            ST_LOAD: begin
                ram_we = accept && phase_lo_reg;
            end
            ST_LOAD_FLUSH: begin
                ram_we    = 1'b1;
                ram_wdata = {hi_reg, NOP_BYTE};
            end
            ST_RUN: begin
                ram_addr  = address[ADDR_W-1:0];
                ram_wdata = wdata;
                ram_we    = wr && !is_io;
            end
            default: begin
            end
        endcase
    end

    stack_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (WORD_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= BOOT_LOAD ? ST_LOAD : ST_RUN;
            cpu_run_reg  <= !BOOT_LOAD;
            ld_ready_reg <= BOOT_LOAD;
            ptr_reg      <= '0;
            phase_lo_reg <= 1'b0;
            hi_reg       <= '0;
            ld_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_LOAD: begin
                    if (accept) begin
                        if (!phase_lo_reg) begin
                            hi_reg       <= ld_byte;
                            phase_lo_reg <= 1'b1;
                            if (ld_last) begin
                                state_reg    <= ST_LOAD_FLUSH;
                                ld_ready_reg <= 1'b0;
                            end
                        end else begin
                            phase_lo_reg <= 1'b0;
                            if (ld_last || ptr_reg == PTR_MAX) begin
                                // Overflow stops the loader; the pointer never wraps.
                                ld_err_reg   <= !ld_last;
                                state_reg    <= ST_RUN;
                                cpu_run_reg  <= 1'b1;
                                ld_ready_reg <= 1'b0;
                            end else begin
                                ptr_reg <= ptr_reg + 1'b1;
                            end
                        end
                    end
                end
                ST_LOAD_FLUSH: begin
                    phase_lo_reg <= 1'b0;
                    state_reg    <= ST_RUN;
                    cpu_run_reg  <= 1'b1;
                    ld_ready_reg <= 1'b0;
                end
                ST_RUN: begin
                    cpu_run_reg  <= 1'b1;
                    ld_ready_reg <= 1'b0;
                end
                default: begin
                    state_reg <= ST_RUN;
                end
            endcase
        end
    end

    // Read-side select and I/O register; rdata stays 0 until the CPU owns the bus.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid_reg <= 1'b0;
            rd_io_reg    <= 1'b0;
            io_q_reg     <= '0;
            io_out_reg   <= '0;
            io_stb_reg   <= 1'b0;
        end else begin
            rd_valid_reg <= (state_reg == ST_RUN);
            rd_io_reg    <= is_io;
            io_q_reg     <= io_in;
            io_stb_reg   <= (state_reg == ST_RUN) && wr && is_io;
            if ((state_reg == ST_RUN) && wr && is_io) begin
                io_out_reg <= wdata;
            end
        end
    end

    assign rdata    = rd_valid_reg ? (rd_io_reg ? io_q_reg : ram_q) : '0;
    assign io_out   = io_out_reg;
    assign io_stb   = io_stb_reg;
    assign ld_ready = ld_ready_reg;
    assign cpu_run  = cpu_run_reg;
    assign ld_err   = ld_err_reg;
endmodule

// File: tb/tb_stack_mem_responder.sv
// Directed bench: boot load, odd image flush, CPU read/write, I/O word, mid-load reset, overflow.
module tb_stack_mem_responder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] address, wdata, io_in;
    logic        wr, ld_valid, ld_last;
    logic [7:0]  ld_byte;
    logic [15:0] rdata, io_out;
    logic        io_stb, ld_ready, cpu_run, ld_err;

    logic        s_rst_n;
    logic [15:0] s_address, s_wdata, s_io_in;
    logic        s_wr, s_ld_valid, s_ld_last;
    logic [7:0]  s_ld_byte;
    logic [15:0] s_rdata, s_io_out;
    logic        s_io_stb, s_ld_ready, s_cpu_run, s_ld_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    stack_mem_responder #(.ADDR_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .address(address), .wdata(wdata), .wr(wr),
        .rdata(rdata), .io_in(io_in), .io_out(io_out), .io_stb(io_stb),
        .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last),
        .ld_ready(ld_ready), .cpu_run(cpu_run), .ld_err(ld_err)
    );

    stack_mem_responder #(.ADDR_W(2)) dut_small (
        .clk(clk), .rst_n(s_rst_n), .address(s_address), .wdata(s_wdata), .wr(s_wr),
        .rdata(s_rdata), .io_in(s_io_in), .io_out(s_io_out), .io_stb(s_io_stb),
        .ld_valid(s_ld_valid), .ld_byte(s_ld_byte), .ld_last(s_ld_last),
        .ld_ready(s_ld_ready), .cpu_run(s_cpu_run), .ld_err(s_ld_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        logic took;
        took     = 1'b0;
        ld_valid = 1'b1;
        ld_byte  = b;
        ld_last  = last;
        for (int i = 0; i < 8 && !took; i++) begin
            took = ld_ready;
            cycle();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        check("byte_accepted", {31'd0, took}, 32'd1);
    endtask

    task automatic cpu_read(input logic [15:0] a, input logic [15:0] exp, input string tag);
        address = a;
        wr      = 1'b0;
        cycle();
        check(tag, {16'd0, rdata}, {16'd0, exp});
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
        address = a;
        wdata   = d;
        wr      = 1'b1;
        cycle();
        wr = 1'b0;
    endtask

    initial begin
        logic [7:0] sb [10];
        int sent;
        logic will;

        rst_n = 1'b0; address = '0; wdata = '0; wr = 1'b0; io_in = '0;
        ld_valid = 1'b0; ld_byte = '0; ld_last = 1'b0;
        s_rst_n = 1'b0; s_address = '0; s_wdata = '0; s_wr = 1'b0; s_io_in = '0;
        s_ld_valid = 1'b0; s_ld_byte = '0; s_ld_last = 1'b0;

        cycle(); cycle();
        check("rst_rdata",    {16'd0, rdata},  32'd0);
        check("rst_io_out",   {16'd0, io_out}, 32'd0);
        check("rst_io_stb",   {31'd0, io_stb}, 32'd0);
        check("rst_ld_err",   {31'd0, ld_err}, 32'd0);
        check("rst_cpu_run",  {31'd0, cpu_run}, 32'd0);
        check("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
        rst_n = 1'b1;

        // Even image: 0x8005, 0x0001
        send_byte(8'h80, 1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(8'h00, 1'b0);
        check("load_cpu_run_low", {31'd0, cpu_run}, 32'd0);
        send_byte(8'h01, 1'b1);
        check("load_cpu_run_high", {31'd0, cpu_run}, 32'd1);
        check("load_ld_ready_low", {31'd0, ld_ready}, 32'd0);
        cpu_read(16'h0000, 16'h8005, "ram0_8005");
        cpu_read(16'h0001, 16'h0001, "ram1_0001");

        // CPU write then read, one-cycle latency
        cpu_write(16'h0003, 16'hBEEF);
        cpu_read(16'h0003, 16'hBEEF, "ram3_beef");
        cpu_read(16'h1003, 16'hBEEF, "alias_1003");
        // Read-before-write on the same address
        address = 16'h0003; wdata = 16'h1111; wr = 1'b1;
        cycle();
        wr = 1'b0;
        check("rbw_old", {16'd0, rdata}, 32'h0000BEEF);
        cpu_read(16'h0003, 16'h1111, "rbw_new");

        // I/O word
        cpu_write(16'h0FFF, 16'h4242);
        address = 16'hFFFF; wdata = 16'h00A5; wr = 1'b1;
        cycle();
        wr = 1'b0;
        check("io_out_a5", {16'd0, io_out}, 32'h000000A5);
        check("io_stb_hi", {31'd0, io_stb}, 32'd1);
        address = 16'h0FFF;
        cycle();
        check("io_stb_lo", {31'd0, io_stb}, 32'd0);
        check("ram_fff_kept", {16'd0, rdata}, 32'h00004242);
        io_in = 16'h1234;
        cpu_read(16'hFFFF, 16'h1234, "io_read");
        check("no_ld_err", {31'd0, ld_err}, 32'd0);

        // Reset mid-load after three bytes
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        send_byte(8'hAB, 1'b0);
        send_byte(8'hCD, 1'b0);
        send_byte(8'hEF, 1'b0);
        rst_n = 1'b0;
        cycle();
        check("mid_rst_ld_ready", {31'd0, ld_ready}, 32'd1);
        check("mid_rst_cpu_run",  {31'd0, cpu_run}, 32'd0);
        check("mid_rst_io_out",   {16'd0, io_out}, 32'd0);
        check("mid_rst_ram0",     {16'd0, dut.u_ram.mem[0]}, 32'h0000ABCD);
        rst_n = 1'b1;

        // Odd image with a stall; the trailing byte is padded by LOAD_FLUSH
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        repeat (5) cycle();
        check("stall_ram1_kept", {16'd0, dut.u_ram.mem[1]}, 32'h00000001);
        check("stall_ld_ready",  {31'd0, ld_ready}, 32'd1);
        send_byte(8'h56, 1'b1);
        check("flush_cpu_run_low",  {31'd0, cpu_run}, 32'd0);
        check("flush_ld_ready_low", {31'd0, ld_ready}, 32'd0);
        cycle();
        check("flush_cpu_run_high", {31'd0, cpu_run}, 32'd1);
        cpu_read(16'h0000, 16'h1234, "odd_ram0");
        cpu_read(16'h0001, 16'h5600, "odd_ram1");

        // Overflow on a 4-word RAM
        for (int k = 0; k < 10; k++) sb[k] = 8'(k + 1);
        s_rst_n = 1'b0; cycle(); s_rst_n = 1'b1;
        sent = 0;
        for (int c = 0; c < 20; c++) begin
            will = 1'b0;
            if (sent < 10) begin
                s_ld_valid = 1'b1;
                s_ld_byte  = sb[sent];
                will       = s_ld_ready;
            end else begin
                s_ld_valid = 1'b0;
            end
            cycle();
            if (will) sent++;
        end
        s_ld_valid = 1'b0;
        check("ovf_bytes_taken", sent, 32'd8);
        check("ovf_ld_err",   {31'd0, s_ld_err}, 32'd1);
        check("ovf_cpu_run",  {31'd0, s_cpu_run}, 32'd1);
        check("ovf_ld_ready", {31'd0, s_ld_ready}, 32'd0);
        s_address = 16'h0000;
        cycle();
        check("ovf_ram0", {16'd0, s_rdata}, 32'h00000102);
        s_address = 16'h0007;
        cycle();
        check("ovf_ram3_alias", {16'd0, s_rdata}, 32'h00000708);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/stack_mem_responder.md
Name: stack_mem_responder

Overview:
- Memory-side responder for the stack CPU's word bus: address, write data, write strobe and read data.
- Contains a synchronous word RAM with one-cycle registered reads.
- Provides a single memory-mapped I/O word.
- Contains a byte-stream boot loader that fills RAM after reset, holding the CPU stopped via cpu_run until the image is complete.

Parameters:
- ADDR_W, 12, RAM depth is 2**ADDR_W 16-bit words; upper address bits are ignored, so addresses alias.
- IO_ADDR, 16'hFFFF, word address decoded as the I/O register instead of RAM.
- BOOT_LOAD, 1, 1 = enter LOAD after reset; 0 = enter RUN directly.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  synchronous active-low reset.
- address  in  16  CPU word address.
- wdata  in  16  CPU write data (CPU data_out).
- wr  in  1  CPU write strobe, sampled each edge.
- rdata  out  16  read data to CPU data_in.
- io_in  in  16  value returned on reads of IO_ADDR.
- io_out  out  16  last value written to IO_ADDR.
- io_stb  out  1  one-cycle pulse on each IO_ADDR write.
- ld_valid  in  1  loader byte valid.
- ld_byte  in  8  loader byte.
- ld_last  in  1  marks the final image byte, qualified by ld_valid.
- ld_ready  out  1  loader accepts a byte when ld_valid && ld_ready.
- cpu_run  out  1  1 = CPU may execute; drives the CPU clock enable.
- ld_err  out  1  sticky flag: image overflowed RAM.

Behaviour:
- Reset values (rst_n low at an edge): rdata=0, io_out=0, io_stb=0, ld_err=0, load pointer=0, byte phase=HI, state=LOAD if BOOT_LOAD else RUN.
  - cpu_run=0 and ld_ready=1 in LOAD.
  - RAM contents are not cleared.
- States: LOAD, LOAD_FLUSH, RUN.
- LOAD:
  - cpu_run=0, ld_ready=1.
  - Bytes arrive big-endian. The first accepted byte is held as word[15:8]. The second byte forms word[7:0] and the word is written to RAM[ptr], then ptr increments.
  - ld_last on a LO byte: write the word, go to RUN.
  - ld_last on a HI byte: go to LOAD_FLUSH.
  - CPU wr is ignored and rdata is forced to 0 while not in RUN.
- LOAD_FLUSH:
  - One cycle, ld_ready=0.
  - Writes {held_hi, 8'h00} to RAM[ptr]. 0x00 is a CPU no-op byte.
  - Next state RUN.
- Overflow: if a word is written at ptr = 2**ADDR_W-1 without ld_last, set ld_err=1 and go to RUN. The pointer does not wrap.
- RUN:
  - cpu_run=1, ld_ready=0, ld_valid ignored.
  - Reads: every edge, rdata <= (address==IO_ADDR) ? io_in : RAM[address[ADDR_W-1:0]]. Latency is exactly one cycle; there is no read enable.
  - Writes: wr high at an edge with address!=IO_ADDR writes RAM[address[ADDR_W-1:0]] <= wdata.
  - Writes with address==IO_ADDR: io_out <= wdata and io_stb=1 for the next cycle only. RAM is unchanged.
  - Same-cycle read and write to one address: rdata returns the old data (read-before-write).
  - wr held high for N edges performs N writes. The CPU holds wr for one edge.
- State stays in RUN until reset. There is no re-load without rst_n.
- Reset mid-load: discard the held byte, ptr=0, restart in LOAD. Words already written stay in RAM.
- Handshake: a byte is consumed only on ld_valid&&ld_ready. The upstream holds ld_byte stable while ld_valid is high and not accepted.

Decomposition:
- Shared package stack_bus_pkg holds:
  - Loader state encoding (LOAD, LOAD_FLUSH, RUN).
  - IO_ADDR default.
  - The NOP byte constant 8'h00.
  - Bus word width 16.
- One sub-module, stack_ram: single-port synchronous RAM with ADDR_W parameter, registered read, read-before-write.
  - Top level muxes the RAM write port between the loader and the CPU.

Test Plan:
- Reset then load bytes 0x80,0x05,0x00,0x01 with ld_last on the 4th -> RAM[0]=0x8005, RAM[1]=0x0001, cpu_run rises the cycle after the final write, ld_ready falls.
- Odd image: bytes 0x12,0x34,0x56 with ld_last on the 3rd -> RAM[1]=0x5600 via LOAD_FLUSH, cpu_run=1 one cycle later.
- RUN: address=3, wr=1, wdata=0xBEEF one edge; next cycle address=3, wr=0 -> rdata=0xBEEF exactly one cycle after the address is presented.
- IO: write 0x00A5 to 0xFFFF -> io_out=0x00A5, io_stb high for one cycle, RAM[0xFFF] unchanged; with io_in=0x1234, a read of 0xFFFF gives rdata=0x1234.
- Overflow with ADDR_W=2: stream 10 bytes without ld_last -> 4 words written, ld_err=1, cpu_run=1, remaining bytes not accepted (ld_ready=0).
- Reset asserted after 3 bytes accepted -> ptr=0, LOAD re-entered, RAM[0] keeps the first word; stall ld_valid low for 5 cycles mid-load -> no spurious writes.
